// File: rtl/dft_2_if.sv
// Butterfly port bundle: input operand pair with valid, registered result pair with valid/overflow.
interface dft_2_if #(
   parameter int unsigned WORD_SZ = 16
);
   logic               i_valid;
   logic [WORD_SZ-1:0] i_A;
   logic [WORD_SZ-1:0] i_B;
   logic               o_valid;
   logic [WORD_SZ-1:0] o_A;
   logic [WORD_SZ-1:0] o_B;
   logic               o_ovf;

   modport master (output i_valid, i_A, i_B, input o_valid, o_A, o_B, o_ovf);
   modport slave  (input i_valid, i_A, i_B, output o_valid, o_A, o_B, o_ovf);
endinterface

// File: rtl/dft_2.sv
// Radix-2 DFT butterfly on packed {real, imag} words: o_A = A + B, o_B = A - B,
// one register stage, optional divide-by-2 scaling.
module dft_2 #(
   parameter int unsigned WORD_SZ = 16,
   parameter bit          SCALE   = 1'b0
) (
   input  logic   i_clk,
   input  logic   i_rst,
   dft_2_if.slave bus
);
   localparam int unsigned H = WORD_SZ / 2;

   logic signed [H:0] a_re, a_im, b_re, b_im;
   logic signed [H:0] sum_re, sum_im, dif_re, dif_im;
   logic [H-1:0]      r_sum_re, r_sum_im, r_dif_re, r_dif_im;
   logic              ovf_c;

   logic [WORD_SZ-1:0] o_a_d, o_a_q;
   logic [WORD_SZ-1:0] o_b_d, o_b_q;
   logic               o_ovf_d, o_ovf_q;
   logic               o_valid_d, o_valid_q;

   // Sign-extended H+1-bit part arithmetic; the extra bit makes overflow exact.
   always_comb begin
      a_re   = {bus.i_A[WORD_SZ-1], bus.i_A[WORD_SZ-1:H]};
      a_im   = {bus.i_A[H-1],       bus.i_A[H-1:0]};
      b_re   = {bus.i_B[WORD_SZ-1], bus.i_B[WORD_SZ-1:H]};
      b_im   = {bus.i_B[H-1],       bus.i_B[H-1:0]};
      sum_re = a_re + b_re;
      sum_im = a_im + b_im;
      dif_re = a_re - b_re;
      dif_im = a_im - b_im;
   end

   // Scaled mode keeps the top H bits (arith >>> 1); unscaled wraps to the low H bits.
   always_comb begin
      r_sum_re = sum_re[H-1:0];
      r_sum_im = sum_im[H-1:0];
      r_dif_re = dif_re[H-1:0];
      r_dif_im = dif_im[H-1:0];
      ovf_c    = (sum_re[H] ^ sum_re[H-1]) | (sum_im[H] ^ sum_im[H-1]) |
                 (dif_re[H] ^ dif_re[H-1]) | (dif_im[H] ^ dif_im[H-1]);
      if (SCALE) begin
         r_sum_re = sum_re[H:1];
         r_sum_im = sum_im[H:1];
         r_dif_re = dif_re[H:1];
         r_dif_im = dif_im[H:1];
         ovf_c    = 1'b0;
      end
   end

   always_comb begin
      o_a_d     = o_a_q;
      o_b_d     = o_b_q;
      o_ovf_d   = o_ovf_q;
      o_valid_d = bus.i_valid;
      if (bus.i_valid) begin
         o_a_d   = {r_sum_re, r_sum_im};
         o_b_d   = {r_dif_re, r_dif_im};
         o_ovf_d = ovf_c;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_a_q     <= '0;
         o_b_q     <= '0;
         o_ovf_q   <= 1'b0;
         o_valid_q <= 1'b0;
      end else begin
         o_a_q     <= o_a_d;
         o_b_q     <= o_b_d;
         o_ovf_q   <= o_ovf_d;
         o_valid_q <= o_valid_d;
      end
   end

   assign bus.o_A     = o_a_q;
   assign bus.o_B     = o_b_q;
   assign bus.o_ovf   = o_ovf_q;
   assign bus.o_valid = o_valid_q;
endmodule

// File: tb/tb_dft_2.sv
// Bench for dft_2: unscaled and scaled instances share stimulus; an integer
// model is checked every cycle, plus hand-computed literal expectations.
module tb_dft_2;
   localparam int unsigned W = 16;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   dft_2_if #(.WORD_SZ(W)) if0 ();
   dft_2_if #(.WORD_SZ(W)) if1 ();

   dft_2 #(.WORD_SZ(W), .SCALE(1'b0)) u0 (.i_clk(clk), .i_rst(rst), .bus(if0));
   dft_2 #(.WORD_SZ(W), .SCALE(1'b1)) u1 (.i_clk(clk), .i_rst(rst), .bus(if1));

   always #5 clk = ~clk;

   logic        in_v;
   logic [15:0] in_a, in_b;
   always_comb begin
      if0.i_valid = in_v; if0.i_A = in_a; if0.i_B = in_b;
      if1.i_valid = in_v; if1.i_A = in_a; if1.i_B = in_b;
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int sx(input logic [7:0] v);
      return (v >= 8'd128) ? int'(v) - 256 : int'(v);
   endfunction

   function automatic int floor_half(input int s);
      return (s < 0 && (s % 2) != 0) ? (s / 2) - 1 : s / 2;
   endfunction

   // Reference butterfly in plain integer arithmetic.
   task automatic model(input logic [15:0] a, input logic [15:0] b, input bit sc,
                        output logic [15:0] oa, output logic [15:0] ob, output logic ov);
      int r[4];
      logic [7:0] q[4];
      r[0] = sx(a[15:8]) + sx(b[15:8]);
      r[1] = sx(a[7:0])  + sx(b[7:0]);
      r[2] = sx(a[15:8]) - sx(b[15:8]);
      r[3] = sx(a[7:0])  - sx(b[7:0]);
      ov = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (sc) r[k] = floor_half(r[k]);
         else if (r[k] > 127 || r[k] < -128) ov = 1'b1;
         q[k] = 8'(r[k]);
      end
      oa = {q[0], q[1]};
      ob = {q[2], q[3]};
   endtask

   logic [15:0] e_a[2], e_b[2];
   logic        e_ovf[2], e_v;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin e_a[k] = '0; e_b[k] = '0; e_ovf[k] = 1'b0; end
         e_v = 1'b0;
      end else begin
         e_v = in_v;
         if (in_v) begin
            model(in_a, in_b, 1'b0, e_a[0], e_b[0], e_ovf[0]);
            model(in_a, in_b, 1'b1, e_a[1], e_b[1], e_ovf[1]);
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_o_A_s0", if0.o_A, 16'h0); chk("rst_o_B_s0", if0.o_B, 16'h0);
         chk("rst_valid_s0", 16'(if0.o_valid), 16'h0); chk("rst_ovf_s0", 16'(if0.o_ovf), 16'h0);
         chk("rst_o_A_s1", if1.o_A, 16'h0); chk("rst_valid_s1", 16'(if1.o_valid), 16'h0);
      end else begin
         chk("mdl_o_A_s0", if0.o_A, e_a[0]); chk("mdl_o_B_s0", if0.o_B, e_b[0]);
         chk("mdl_ovf_s0", 16'(if0.o_ovf), 16'(e_ovf[0]));
         chk("mdl_valid_s0", 16'(if0.o_valid), 16'(e_v));
         chk("mdl_o_A_s1", if1.o_A, e_a[1]); chk("mdl_o_B_s1", if1.o_B, e_b[1]);
         chk("mdl_ovf_s1", 16'(if1.o_ovf), 16'(e_ovf[1]));
         chk("mdl_valid_s1", 16'(if1.o_valid), 16'(e_v));
      end
   end

   task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic v);
      @(negedge clk);
      in_a = a; in_b = b; in_v = v;
   endtask

   task automatic after_edge();
      @(posedge clk); #1;
   endtask

   initial begin
      in_v = 1'b0; in_a = '0; in_b = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("lit_reset_o_A", if0.o_A, 16'h0);
      chk("lit_reset_valid", 16'(if0.o_valid), 16'h0);
      @(negedge clk); rst = 1'b0;

      // Basic butterfly
      drive(16'h0203, 16'h0401, 1'b1); after_edge();
      chk("lit1_o_A_s0", if0.o_A, 16'h0604); chk("lit1_o_B_s0", if0.o_B, 16'hFE02);
      chk("lit1_valid", 16'(if0.o_valid), 16'h1); chk("lit1_ovf", 16'(if0.o_ovf), 16'h0);
      chk("lit3_o_A_s1", if1.o_A, 16'h0302); chk("lit3_o_B_s1", if1.o_B, 16'hFF01);

      // Overflow boundaries
      drive(16'h7F00, 16'h0100, 1'b1); after_edge();
      chk("lit2a_o_A_s0", if0.o_A, 16'h8000); chk("lit2a_ovf_s0", 16'(if0.o_ovf), 16'h1);
      chk("lit2a_o_A_s1", if1.o_A, 16'h4000); chk("lit2a_ovf_s1", 16'(if1.o_ovf), 16'h0);
      drive(16'h8000, 16'h0100, 1'b1); after_edge();
      chk("lit2b_o_B_s0", if0.o_B, 16'h7F00); chk("lit2b_ovf_s0", 16'(if0.o_ovf), 16'h1);
      chk("lit2b_o_A_s0", if0.o_A, 16'h8100);
      chk("lit2b_o_B_s1", if1.o_B, 16'hBF00); chk("lit2b_o_A_s1", if1.o_A, 16'hC000);
      drive(16'h7F7F, 16'h7F7F, 1'b1); after_edge();
      chk("lit3b_o_A_s1", if1.o_A, 16'h7F7F); chk("lit3b_o_B_s1", if1.o_B, 16'h0000);
      chk("lit3b_o_A_s0", if0.o_A, 16'hFEFE); chk("lit3b_ovf_s0", 16'(if0.o_ovf), 16'h1);

      // Back-to-back stream, then idle hold
      drive(16'h1020, 16'h0304, 1'b1);
      drive(16'hF0F0, 16'h1010, 1'b1);
      drive(16'h8080, 16'h7F7F, 1'b1);
      drive(16'h0101, 16'h0101, 1'b1);
      drive(16'h5555, 16'h2222, 1'b0);
      repeat (3) after_edge();
      chk("lit4_hold_o_A", if0.o_A, 16'h0202); chk("lit4_hold_o_B", if0.o_B, 16'h0000);
      chk("lit4_hold_valid", 16'(if0.o_valid), 16'h0);

      // Asynchronous reset between edges
      drive(16'h1122, 16'h0304, 1'b1); after_edge();
      #2 rst = 1'b1;
      #1 chk("lit5_async_o_A", if0.o_A, 16'h0); chk("lit5_async_o_B", if1.o_B, 16'h0);
      chk("lit5_async_valid", 16'(if0.o_valid), 16'h0);
      in_v = 1'b0;
      @(negedge clk); rst = 1'b0;
      drive(16'h0203, 16'h0401, 1'b1); after_edge();
      chk("lit5_post_o_A", if0.o_A, 16'h0604); chk("lit5_post_o_B", if0.o_B, 16'hFE02);

      // Random vectors checked by the model
      for (int n = 0; n < 1000; n++)
         drive(16'($urandom), 16'($urandom), ($urandom_range(0, 7) != 0));
      drive(16'h0, 16'h0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
